rs_array: RTL and testbench
===========================

# rs_array

Parametrised N-entry reservation station that replaces the fixed two-ALU/one-memory slot arrangement with a single array of identical entries. It sits between dispatch and the execute stage: it accepts one instruction per cycle, tracks operand readiness by ROB tag, and captures values broadcast on the CDB. It issues one ready entry per cycle over a valid/ready handshake and frees the entry on issue.

## Interface
Parameters:
- NUM_ENTRIES, 8, number of entries; must be at least 2.
- XLEN, 32, operand value width.
- TAG_W, 5, ROB tag width.
- PAYLOAD_W, 64, opaque decoded-control payload width, passed through unchanged.

Ports:
- clock  in  1  single clock; one clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset.
- dp_valid  in  1  dispatch request.
- dp_ready  out  1  at least one entry is free (registered state only).
- dp_payload  in  PAYLOAD_W  control payload.
- dp_dest_tag  in  TAG_W  ROB tag of the instruction.
- dp_src1_ready, dp_src2_ready  in  1  operand value already valid.
- dp_src1_tag, dp_src2_tag  in  TAG_W  producer tag when not ready.
- dp_src1_value, dp_src2_value  in  XLEN  operand value when ready.
- cdb_valid  in  1  CDB broadcast.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  XLEN  broadcast value.
- flush  in  1  squash all entries.
- iss_valid  out  1  a selected entry has both operands ready.
- iss_ready  in  1  execute stage accepts.
- iss_payload  out  PAYLOAD_W  payload of the selected entry.
- iss_dest_tag  out  TAG_W  tag of the selected entry.
- iss_src1_value, iss_src2_value  out  XLEN  operands of the selected entry.
- free_count  out  $clog2(NUM_ENTRIES+1)  number of free entries.

## Operation
- Entry state: valid, payload, dest_tag, and per source {rdy, tag, value}.
- Allocation:
  - A dispatch occurs when dp_valid && dp_ready && !flush.
  - The lowest-index free entry is written.
- Dispatch-time bypass: if cdb_valid and cdb_tag equals a not-ready source tag in the same cycle, that source is written rdy=1 with cdb_value.
- Wakeup:
  - Each cycle, every valid entry compares each not-ready source tag against cdb_tag.
  - On a match while cdb_valid is high, rdy is set and cdb_value is captured.
  - Ready sources ignore the CDB.
- Select:
  - The candidate set is the valid entries with both rdy bits set.
  - The chosen entry drives the iss_* outputs combinationally from registered state.
  - When no candidate exists, iss_valid=0 and all iss_* data outputs are 0.
- Issue:
  - The handshake fires when iss_valid && iss_ready.
  - The chosen entry's valid bit is cleared at that edge.
  - iss_valid may stay high over several cycles while iss_ready is low; the selection may change if an older entry becomes ready.
- Simultaneous dispatch and issue:
  - Both take effect.
  - dp_ready does not count the entry being freed this cycle.
- Flush:
  - All valid bits are cleared at the next edge.
  - iss_valid is forced to 0 while flush is high.
  - Dispatch is ignored while flush is high.
- free_count equals NUM_ENTRIES minus the number of valid entries; it updates at each edge.

## Timing
- Reset (asynchronous, reset_n=0):
  - All entries are invalid.
  - iss_valid=0, all iss_* data outputs are 0.
  - dp_ready=1, free_count=NUM_ENTRIES.
  - Any age state is cleared.
- Dispatch with both sources ready at edge N: iss_valid can assert in cycle N+1. There is no same-cycle dispatch-to-issue path.
- CDB wakeup at edge N: the entry can issue in cycle N+1.
- Full array: dp_ready=0, and dp_valid is ignored.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Configuration
- RS_AGE_SELECT_EN defined:
  - An NUM_ENTRIES×NUM_ENTRIES age matrix records relative dispatch order.
  - The select logic issues the oldest ready entry.
  - Flush and reset clear the matrix.
- RS_AGE_SELECT_EN undefined:
  - No age state is kept.
  - The select logic issues the lowest-index ready entry.

## Test plan
- Reset, then dispatch 8 instructions with all sources ready and iss_ready=0 -> dp_ready=0 and free_count=0 after the 8th edge; a 9th dispatch is dropped; iss_valid=1 selects entry 0.
- Dispatch with src1 not ready on tag 3, then CDB tag 3 value 0xDEADBEEF two cycles later -> iss_valid rises the cycle after the broadcast, and iss_src1_value=0xDEADBEEF.
- Dispatch with src2 not ready on tag 7 in the same cycle as CDB tag 7 value 0x55 -> the entry captures 0x55, and iss_valid=1 the next cycle.
- Fill entries 0..3 in order A,B,C,D, issue A and B, then dispatch E into entry 0 and make all entries ready -> with RS_AGE_SELECT_EN the issue order is C,D,E; without it the order is E,C,D.
- Full array with iss_ready=1 and dp_valid=1 in one cycle -> the issue fires, the dispatch is not accepted, and free_count=1 the next cycle.
- Flush with 5 valid entries and iss_ready=1 -> no issue fires that cycle, free_count=8 the next cycle; asserting reset_n=0 mid-cycle clears iss_valid without waiting for a clock edge.

Source files
------------

// File: rtl/rs_array_if.sv
// Dispatch / CDB / issue bundle for the rs_array reservation station.
// master drives dispatch, CDB, flush and issue-accept; slave is the station.
interface rs_array_if #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned PAYLOAD_W   = 64
) ();

  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  // Dispatch
  logic                 dp_valid;
  logic                 dp_ready;
  logic [PAYLOAD_W-1:0] dp_payload;
  logic [TAG_W-1:0]     dp_dest_tag;
  logic                 dp_src1_ready;
  logic                 dp_src2_ready;
  logic [TAG_W-1:0]     dp_src1_tag;
  logic [TAG_W-1:0]     dp_src2_tag;
  logic [XLEN-1:0]      dp_src1_value;
  logic [XLEN-1:0]      dp_src2_value;

  // Common data bus broadcast and squash
  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic [XLEN-1:0]      cdb_value;
  logic                 flush;

  // Issue
  logic                 iss_valid;
  logic                 iss_ready;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [TAG_W-1:0]     iss_dest_tag;
  logic [XLEN-1:0]      iss_src1_value;
  logic [XLEN-1:0]      iss_src2_value;

  logic [CNT_W-1:0]     free_count;

  modport master (
    output dp_valid, dp_payload, dp_dest_tag,
           dp_src1_ready, dp_src2_ready, dp_src1_tag, dp_src2_tag,
           dp_src1_value, dp_src2_value,
           cdb_valid, cdb_tag, cdb_value, flush, iss_ready,
    input  dp_ready, iss_valid, iss_payload, iss_dest_tag,
           iss_src1_value, iss_src2_value, free_count
  );

  modport slave (
    input  dp_valid, dp_payload, dp_dest_tag,
           dp_src1_ready, dp_src2_ready, dp_src1_tag, dp_src2_tag,
           dp_src1_value, dp_src2_value,
           cdb_valid, cdb_tag, cdb_value, flush, iss_ready,
    output dp_ready, iss_valid, iss_payload, iss_dest_tag,
           iss_src1_value, iss_src2_value, free_count
  );

endinterface

// File: rtl/rs_array.sv
// rs_array: N-entry unified reservation station.
// Allocates lowest free entry, wakes operands from the CDB (including same-cycle
// bypass at dispatch), and issues one ready entry per cycle over valid/ready.
// Optional macro RS_AGE_SELECT_EN: keep an age matrix and issue the oldest
// ready entry; otherwise the lowest-index ready entry is issued.
module rs_array #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned PAYLOAD_W   = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  rs_array_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  // Entry state
  logic [NUM_ENTRIES-1:0] valid_q,  valid_d;
  logic [NUM_ENTRIES-1:0] s1_rdy_q, s1_rdy_d;
  logic [NUM_ENTRIES-1:0] s2_rdy_q, s2_rdy_d;
  logic [TAG_W-1:0]       s1_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       s1_tag_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       s2_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       s2_tag_d [NUM_ENTRIES];
  logic [XLEN-1:0]        s1_val_q [NUM_ENTRIES];
  logic [XLEN-1:0]        s1_val_d [NUM_ENTRIES];
  logic [XLEN-1:0]        s2_val_q [NUM_ENTRIES];
  logic [XLEN-1:0]        s2_val_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_d   [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   pay_q    [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   pay_d    [NUM_ENTRIES];

  // Occupancy status, registered from the next-state valid vector
  logic [CNT_W-1:0]       free_cnt_q, free_cnt_d;
  logic                   dp_ready_q, dp_ready_d;
  logic [CNT_W-1:0]       busy_cnt;

  logic [NUM_ENTRIES-1:0] cand;
  logic                   any_cand;
  logic [IDX_W-1:0]       sel_idx;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   iss_valid_c;
  logic                   iss_fire;
  logic                   dp_fire;

  assign cand        = valid_q & s1_rdy_q & s2_rdy_q;
  assign any_cand    = |cand;
  assign iss_valid_c = any_cand && !bus.flush;
  assign iss_fire    = iss_valid_c && bus.iss_ready;
  assign dp_fire     = bus.dp_valid && dp_ready_q && !bus.flush;

  // Lowest-index free entry (descending scan so the lowest wins)
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

`ifdef RS_AGE_SELECT_EN
  // age_q[j][i] set means entry j was dispatched before entry i
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q, age_d;
  logic [NUM_ENTRIES-1:0]                  blocked;

  // A candidate is blocked when some older entry is also a candidate
  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && cand[j] && age_q[j][i]) blocked[i] = 1'b1;
      end
    end
  end

  // Oldest ready entry; exactly one unblocked candidate exists
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (cand[i] && !blocked[i]) sel_idx = IDX_W'(i);
    end
  end

  // New entry becomes younger than every other slot; flush clears order
  always_comb begin
    age_d = age_q;
    if (dp_fire) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        age_d[alloc_idx][j] = 1'b0;
        age_d[j][alloc_idx] = 1'b1;
      end
      age_d[alloc_idx][alloc_idx] = 1'b0;
    end
    if (bus.flush) age_d = '0;
  end

  // Age matrix register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) age_q <= '0;
    else          age_q <= age_d;
  end
`else
  // Lowest-index ready entry
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  // Next entry state: wakeup, issue free, allocation with CDB bypass, flush
  always_comb begin
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    s1_tag_d = s1_tag_q;
    s2_tag_d = s2_tag_q;
    s1_val_d = s1_val_q;
    s2_val_d = s2_val_q;
    dest_d   = dest_q;
    pay_d    = pay_q;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && bus.cdb_valid) begin
        if (!s1_rdy_q[i] && (s1_tag_q[i] == bus.cdb_tag)) begin
          s1_rdy_d[i] = 1'b1;
          s1_val_d[i] = bus.cdb_value;
        end
        if (!s2_rdy_q[i] && (s2_tag_q[i] == bus.cdb_tag)) begin
          s2_rdy_d[i] = 1'b1;
          s2_val_d[i] = bus.cdb_value;
        end
      end
    end

    if (iss_fire) valid_d[sel_idx] = 1'b0;

    if (dp_fire) begin
      valid_d[alloc_idx]  = 1'b1;
      pay_d[alloc_idx]    = bus.dp_payload;
      dest_d[alloc_idx]   = bus.dp_dest_tag;
      s1_tag_d[alloc_idx] = bus.dp_src1_tag;
      s2_tag_d[alloc_idx] = bus.dp_src2_tag;
      if (bus.dp_src1_ready) begin
        s1_rdy_d[alloc_idx] = 1'b1;
        s1_val_d[alloc_idx] = bus.dp_src1_value;
      end else if (bus.cdb_valid && (bus.cdb_tag == bus.dp_src1_tag)) begin
        s1_rdy_d[alloc_idx] = 1'b1;
        s1_val_d[alloc_idx] = bus.cdb_value;
      end else begin
        s1_rdy_d[alloc_idx] = 1'b0;
        s1_val_d[alloc_idx] = '0;
      end
      if (bus.dp_src2_ready) begin
        s2_rdy_d[alloc_idx] = 1'b1;
        s2_val_d[alloc_idx] = bus.dp_src2_value;
      end else if (bus.cdb_valid && (bus.cdb_tag == bus.dp_src2_tag)) begin
        s2_rdy_d[alloc_idx] = 1'b1;
        s2_val_d[alloc_idx] = bus.cdb_value;
      end else begin
        s2_rdy_d[alloc_idx] = 1'b0;
        s2_val_d[alloc_idx] = '0;
      end
    end

    if (bus.flush) valid_d = '0;
  end

  // Free count and dispatch-ready derived from the next valid vector
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      busy_cnt = busy_cnt + CNT_W'(valid_d[i]);
    end
    free_cnt_d = CNT_W'(NUM_ENTRIES) - busy_cnt;
    dp_ready_d = (free_cnt_d != '0);
  end

  // Entry and status registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      s1_rdy_q   <= '0;
      s2_rdy_q   <= '0;
      free_cnt_q <= CNT_W'(NUM_ENTRIES);
      dp_ready_q <= 1'b1;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        s1_tag_q[i] <= '0;
        s2_tag_q[i] <= '0;
        s1_val_q[i] <= '0;
        s2_val_q[i] <= '0;
        dest_q[i]   <= '0;
        pay_q[i]    <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      s1_rdy_q   <= s1_rdy_d;
      s2_rdy_q   <= s2_rdy_d;
      free_cnt_q <= free_cnt_d;
      dp_ready_q <= dp_ready_d;
      s1_tag_q   <= s1_tag_d;
      s2_tag_q   <= s2_tag_d;
      s1_val_q   <= s1_val_d;
      s2_val_q   <= s2_val_d;
      dest_q     <= dest_d;
      pay_q      <= pay_d;
    end
  end

  // Issue outputs: selected entry, zeroed when nothing is issuable
  always_comb begin
    bus.iss_valid      = iss_valid_c;
    bus.iss_payload    = '0;
    bus.iss_dest_tag   = '0;
    bus.iss_src1_value = '0;
    bus.iss_src2_value = '0;
    if (iss_valid_c) begin
      bus.iss_payload    = pay_q[sel_idx];
      bus.iss_dest_tag   = dest_q[sel_idx];
      bus.iss_src1_value = s1_val_q[sel_idx];
      bus.iss_src2_value = s2_val_q[sel_idx];
    end
  end

  assign bus.dp_ready   = dp_ready_q;
  assign bus.free_count = free_cnt_q;

endmodule

// File: tb/tb_rs_array.sv
// Directed testbench for rs_array: fill/full, CDB wakeup and bypass,
// select order, simultaneous issue/dispatch, flush and async reset.
module tb_rs_array;

  localparam int unsigned NE = 8;
  localparam int unsigned XL = 32;
  localparam int unsigned TW = 5;
  localparam int unsigned PW = 64;
  localparam logic [PW-1:0] PAY_BASE = 64'h1234_0000_0000_0000;

  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  rs_array_if #(.NUM_ENTRIES(NE), .XLEN(XL), .TAG_W(TW), .PAYLOAD_W(PW)) bus ();

  rs_array #(.NUM_ENTRIES(NE), .XLEN(XL), .TAG_W(TW), .PAYLOAD_W(PW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One dispatch request held across one clock edge; payload encodes dest
  task automatic dispatch(input logic [TW-1:0] dest,
                          input logic r1, input logic [TW-1:0] t1, input logic [XL-1:0] v1,
                          input logic r2, input logic [TW-1:0] t2, input logic [XL-1:0] v2);
    bus.dp_valid      = 1'b1;
    bus.dp_payload    = PAY_BASE | 64'(dest);
    bus.dp_dest_tag   = dest;
    bus.dp_src1_ready = r1;
    bus.dp_src1_tag   = t1;
    bus.dp_src1_value = v1;
    bus.dp_src2_ready = r2;
    bus.dp_src2_tag   = t2;
    bus.dp_src2_value = v2;
    @(negedge clock);
    bus.dp_valid = 1'b0;
  endtask

  task automatic cdb(input logic [TW-1:0] tag, input logic [XL-1:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = val;
    @(negedge clock);
    bus.cdb_valid = 1'b0;
  endtask

  // Accept one issue and check it carries the expected dest tag and payload
  task automatic issue_expect(input logic [TW-1:0] dest);
    bus.iss_ready = 1'b1;
    #1;
    check("iss_valid", 64'(bus.iss_valid), 64'd1);
    check("iss_dest_tag", 64'(bus.iss_dest_tag), 64'(dest));
    check("iss_payload", bus.iss_payload, PAY_BASE | 64'(dest));
    @(negedge clock);
    bus.iss_ready = 1'b0;
  endtask

  initial begin
    reset_n           = 1'b0;
    bus.dp_valid      = 1'b0;
    bus.dp_payload    = '0;
    bus.dp_dest_tag   = '0;
    bus.dp_src1_ready = 1'b0;
    bus.dp_src2_ready = 1'b0;
    bus.dp_src1_tag   = '0;
    bus.dp_src2_tag   = '0;
    bus.dp_src1_value = '0;
    bus.dp_src2_value = '0;
    bus.cdb_valid     = 1'b0;
    bus.cdb_tag       = '0;
    bus.cdb_value     = '0;
    bus.flush         = 1'b0;
    bus.iss_ready     = 1'b0;

    @(negedge clock);
    check("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("rst_iss_payload", bus.iss_payload, 64'd0);
    check("rst_dp_ready", 64'(bus.dp_ready), 64'd1);
    check("rst_free_count", 64'(bus.free_count), 64'd8);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Fill all entries with ready operands, then try a 9th
    for (int i = 0; i < 8; i++) begin
      dispatch(TW'(i), 1'b1, '0, XL'(100 + i), 1'b1, '0, XL'(200 + i));
    end
    check("full_dp_ready", 64'(bus.dp_ready), 64'd0);
    check("full_free_count", 64'(bus.free_count), 64'd0);
    check("full_iss_valid", 64'(bus.iss_valid), 64'd1);
    check("full_sel_dest", 64'(bus.iss_dest_tag), 64'd0);
    check("full_sel_src1", 64'(bus.iss_src1_value), 64'd100);
    check("full_sel_src2", 64'(bus.iss_src2_value), 64'd200);
    dispatch(TW'(20), 1'b1, '0, 32'h1, 1'b1, '0, 32'h2);
    check("drop_free_count", 64'(bus.free_count), 64'd0);
    for (int i = 0; i < 8; i++) issue_expect(TW'(i));
    check("drain_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("drain_free_count", 64'(bus.free_count), 64'd8);

    // Full array: issue and dispatch in the same cycle
    for (int i = 0; i < 8; i++) begin
      dispatch(TW'(8 + i), 1'b1, '0, XL'(i), 1'b1, '0, XL'(i));
    end
    bus.iss_ready = 1'b1;
    #1;
    check("fi_iss_valid", 64'(bus.iss_valid), 64'd1);
    check("fi_iss_dest", 64'(bus.iss_dest_tag), 64'd8);
    dispatch(TW'(30), 1'b1, '0, 32'h3, 1'b1, '0, 32'h3);
    bus.iss_ready = 1'b0;
    check("fi_free_count", 64'(bus.free_count), 64'd1);
    check("fi_dp_ready", 64'(bus.dp_ready), 64'd1);
    for (int i = 1; i < 8; i++) issue_expect(TW'(8 + i));
    check("fi_no_extra", 64'(bus.iss_valid), 64'd0);

    // Wakeup: src1 waits on tag 3, unrelated broadcast first
    dispatch(TW'(9), 1'b0, TW'(3), 32'h0, 1'b1, '0, 32'h22);
    check("wk_wait0", 64'(bus.iss_valid), 64'd0);
    cdb(TW'(4), 32'h1111);
    check("wk_wrong_tag", 64'(bus.iss_valid), 64'd0);
    cdb(TW'(3), 32'hDEAD_BEEF);
    check("wk_iss_valid", 64'(bus.iss_valid), 64'd1);
    check("wk_src1", 64'(bus.iss_src1_value), 64'hDEAD_BEEF);
    check("wk_src2", 64'(bus.iss_src2_value), 64'h22);
    issue_expect(TW'(9));

    // Dispatch-time bypass on src2
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = TW'(7);
    bus.cdb_value = 32'h55;
    dispatch(TW'(10), 1'b1, '0, 32'h11, 1'b0, TW'(7), 32'h0);
    bus.cdb_valid = 1'b0;
    check("byp_iss_valid", 64'(bus.iss_valid), 64'd1);
    check("byp_src2", 64'(bus.iss_src2_value), 64'h55);
    check("byp_src1", 64'(bus.iss_src1_value), 64'h11);
    issue_expect(TW'(10));

    // Select order: A,B ready; C,D,E wait on tag 9; E lands in entry 0
    dispatch(TW'(1), 1'b1, '0, 32'h1, 1'b1, '0, 32'h1);
    dispatch(TW'(2), 1'b1, '0, 32'h2, 1'b1, '0, 32'h2);
    dispatch(TW'(3), 1'b0, TW'(9), 32'h0, 1'b1, '0, 32'h3);
    dispatch(TW'(4), 1'b0, TW'(9), 32'h0, 1'b1, '0, 32'h4);
    issue_expect(TW'(1));
    issue_expect(TW'(2));
    check("age_none_ready", 64'(bus.iss_valid), 64'd0);
    dispatch(TW'(5), 1'b0, TW'(9), 32'h0, 1'b1, '0, 32'h5);
    check("age_free_count", 64'(bus.free_count), 64'd5);
    cdb(TW'(9), 32'h99);
    check("age_src1", 64'(bus.iss_src1_value), 64'h99);
`ifdef RS_AGE_SELECT_EN
    issue_expect(TW'(3));
    issue_expect(TW'(4));
    issue_expect(TW'(5));
`else
    issue_expect(TW'(5));
    issue_expect(TW'(3));
    issue_expect(TW'(4));
`endif
    check("age_empty", 64'(bus.iss_valid), 64'd0);

    // Flush with 5 valid entries, issue accept and a dispatch attempt
    for (int i = 0; i < 5; i++) begin
      dispatch(TW'(16 + i), 1'b1, '0, 32'h7, 1'b1, '0, 32'h8);
    end
    check("fl_pre_count", 64'(bus.free_count), 64'd3);
    bus.flush     = 1'b1;
    bus.iss_ready = 1'b1;
    #1;
    check("fl_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("fl_iss_dest", 64'(bus.iss_dest_tag), 64'd0);
    dispatch(TW'(25), 1'b1, '0, 32'h9, 1'b1, '0, 32'h9);
    bus.flush     = 1'b0;
    bus.iss_ready = 1'b0;
    check("fl_free_count", 64'(bus.free_count), 64'd8);
    check("fl_post_valid", 64'(bus.iss_valid), 64'd0);

    // Asynchronous reset between clock edges
    dispatch(TW'(21), 1'b1, '0, 32'hAB, 1'b1, '0, 32'hCD);
    check("ar_pre_valid", 64'(bus.iss_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("ar_iss_src1", 64'(bus.iss_src1_value), 64'd0);
    check("ar_free_count", 64'(bus.free_count), 64'd8);
    check("ar_dp_ready", 64'(bus.dp_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("ar_post_valid", 64'(bus.iss_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
